// File: rtl/i2c_pkg.sv
// Shared constants and types for the ball-handoff I2C link.
package i2c_pkg;

  // State codes are exposed on led[15:12], so keep them stable.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_DATA     = 4'd3,
    ST_DATA_ACK = 4'd4,
    ST_IGNORE   = 4'd5
  } i2c_state_t;

  localparam int BALL_FRAME_BYTES = 3;
  localparam int BALL_Y_W         = 10;
  localparam int BALL_VY_W        = 8;
  // Upper y bits travel in the low end of data byte 0; byte 1 carries y[7:0].
  localparam int BALL_Y_HI_W      = BALL_Y_W - 8;

  typedef struct packed {
    logic [BALL_Y_W-1:0]  y;
    logic [BALL_VY_W-1:0] vy;
  } ball_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with registered edge, START and STOP pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_h, sda_h;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  // SDA level time-aligned with the registered pulses below.
  assign sda   = sda_h;

  // Metastability chain plus one history flop; resets to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_h    <= scl_s;
      sda_h    <= sda_s;
    end
  end

  // START/STOP need SCL high on both samples, so an SDA edge coinciding with
  // an SCL rise is treated as a data bit, never as a bus condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_rise <= scl_s & ~scl_h;
      scl_fall <= ~scl_s & scl_h;
      start    <= scl_s & scl_h & sda_h & ~sda_s;
      stop     <= scl_s & scl_h & ~sda_h & sda_s;
    end
  end

endmodule

// File: rtl/i2c_ball_slave.sv
// I2C write-only target receiving 3-byte ball frames (y position, y velocity).
module i2c_ball_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic       ball_valid,
  output logic       is_receive,
  output logic [15:0] led
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (reset),
    .scl_in   (SCL),
    .sda_in   (SDA),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [1:0] byte_cnt, byte_cnt_n;
  logic [7:0] shift, shift_n, byte_v;
  logic [BALL_FRAME_BYTES-1:0][7:0] hold, hold_n;
  logic bad, bad_n, sda_low, sda_low_n, is_recv_n, commit, commit_n;
  ball_t ball;

  // Open-drain: only ever pull low; the reset path clears sda_low asynchronously.
  assign SDA        = sda_low ? 1'b0 : 1'bz;
  assign ball_y     = ball.y;
  assign ball_vy    = ball.vy;
  assign led        = {state, 2'b00, ball.y};

  // FSM and frame-tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      hold       <= '0;
      bad        <= 1'b0;
      sda_low    <= 1'b0;
      is_receive <= 1'b0;
      commit     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      shift      <= shift_n;
      hold       <= hold_n;
      bad        <= bad_n;
      sda_low    <= sda_low_n;
      is_receive <= is_recv_n;
      commit     <= commit_n;
    end
  end

  // Next state: START/STOP override everything; otherwise bits shift on SCL
  // rise and the ACK slot is framed by two consecutive SCL falls.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shift_n    = shift;
    hold_n     = hold;
    bad_n      = bad;
    sda_low_n  = sda_low;
    is_recv_n  = is_receive;
    commit_n   = 1'b0;
    byte_v     = {shift[6:0], sda};

    if (start) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = '0;
      byte_cnt_n = '0;
      shift_n    = '0;
      bad_n      = 1'b0;
      sda_low_n  = 1'b0;
      is_recv_n  = 1'b0;
    end else if (stop) begin
      commit_n   = (int'(byte_cnt) == BALL_FRAME_BYTES) && !bad;
      state_n    = ST_IDLE;
      bit_cnt_n  = '0;
      byte_cnt_n = '0;
      bad_n      = 1'b0;
      sda_low_n  = 1'b0;
      is_recv_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shift_n   = byte_v;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                if (byte_v == {SLAVE_ADDR, 1'b0}) begin
                  state_n    = ST_ADDR_ACK;
                  is_recv_n  = 1'b1;
                  byte_cnt_n = '0;
                end else begin
                  state_n = ST_IGNORE;
                end
              end else if (int'(byte_cnt) < BALL_FRAME_BYTES) begin
                hold_n[byte_cnt] = byte_v;
                state_n          = ST_DATA_ACK;
              end else begin
                // Surplus byte: NACK it and poison the frame.
                bad_n   = 1'b1;
                state_n = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_low) begin
              sda_low_n = 1'b1;
            end else begin
              sda_low_n = 1'b0;
              state_n   = ST_DATA;
              bit_cnt_n = '0;
              if (state == ST_DATA_ACK) byte_cnt_n = byte_cnt + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Committed ball outputs, loaded one clk after the STOP decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball       <= '0;
      ball_valid <= 1'b0;
    end else begin
      ball_valid <= commit;
      if (commit) begin
        ball.y  <= {hold[0][BALL_Y_HI_W-1:0], hold[1]};
        ball.vy <= hold[2];
      end
    end
  end

endmodule
